// File: rtl/playback_checker.sv
// playback_checker: plays stimulus vectors from an internal table onto a DUT
// input bus and checks the DUT output against masked reference vectors after
// a fixed latency, reporting pass/fail, a saturating mismatch count and the
// index of the first failing vector.
// Optional feature macro: PLAYBACK_CHECKER_BITLOG_EN adds first_fail_bit.

module playback_checker #(
  parameter int IN_WIDTH     = 361,
  parameter int OUT_WIDTH    = 331,
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = 10,
  parameter int CMP_LATENCY  = 1,
  parameter int SKIP_VECTORS = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [IN_WIDTH-1:0]   load_stim,
  input  logic [OUT_WIDTH-1:0]  load_ref,
  input  logic [OUT_WIDTH-1:0]  load_mask,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_vectors,
  input  logic                  stop_on_fail,
  output logic [IN_WIDTH-1:0]   dut_in,
  input  logic [OUT_WIDTH-1:0]  dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic [ADDR_WIDTH-1:0] first_fail_idx
`ifdef PLAYBACK_CHECKER_BITLOG_EN
  ,
  output logic [$clog2(OUT_WIDTH)-1:0] first_fail_bit
`endif
);

  localparam int                  LAST       = CMP_LATENCY - 1;
  localparam logic [ADDR_WIDTH:0] SKIP_IDX   = (ADDR_WIDTH+1)'(SKIP_VECTORS);
  localparam logic [3:0]          DRAIN_LAST = 4'(CMP_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [IN_WIDTH-1:0]  stim_mem [DEPTH];
  logic [OUT_WIDTH-1:0] ref_mem  [DEPTH];
  logic [OUT_WIDTH-1:0] mask_mem [DEPTH];

  logic [ADDR_WIDTH:0]   num_q, num_d, issue_q, issue_d;
  logic                  stop_q, stop_d;
  logic [3:0]            drain_q, drain_d;
  logic [IN_WIDTH-1:0]   dut_in_q, dut_in_d;
  logic                  pass_q, pass_d;
  logic [CNT_WIDTH-1:0]  mismatch_count_q, mismatch_count_d;
  logic [ADDR_WIDTH-1:0] first_fail_idx_q, first_fail_idx_d;

  // Compare delay line: what each issued vector should produce, CMP_LATENCY deep
  logic [OUT_WIDTH-1:0]  ref_pipe_q  [CMP_LATENCY];
  logic [OUT_WIDTH-1:0]  ref_pipe_d  [CMP_LATENCY];
  logic [OUT_WIDTH-1:0]  mask_pipe_q [CMP_LATENCY];
  logic [OUT_WIDTH-1:0]  mask_pipe_d [CMP_LATENCY];
  logic [ADDR_WIDTH-1:0] idx_pipe_q  [CMP_LATENCY];
  logic [ADDR_WIDTH-1:0] idx_pipe_d  [CMP_LATENCY];
  logic [CMP_LATENCY-1:0] en_pipe_q, en_pipe_d, vld_pipe_q, vld_pipe_d;

  logic                  running, fail, abort, issue, last_issue;
  logic [OUT_WIDTH-1:0]  diff;
  logic [ADDR_WIDTH-1:0] rd_addr;

`ifdef PLAYBACK_CHECKER_BITLOG_EN
  logic [$clog2(OUT_WIDTH)-1:0] first_fail_bit_q, first_fail_bit_d, fail_bit;
`endif

  // Table writes from the loader; refused while a run is in progress
  always_ff @(posedge clk) begin
    if (load_valid && !running) begin
      stim_mem[load_addr] <= load_stim;
      ref_mem[load_addr]  <= load_ref;
      mask_mem[load_addr] <= load_mask;
    end
  end

  // Masked compare of the oldest delay-line entry and the issue/abort decision
  always_comb begin
    running    = (state_q == RUN) || (state_q == DRAIN);
    rd_addr    = issue_q[ADDR_WIDTH-1:0];
    diff       = (dut_out ^ ref_pipe_q[LAST]) & mask_pipe_q[LAST];
    fail       = running && vld_pipe_q[LAST] && en_pipe_q[LAST] && (|diff);
    abort      = fail && stop_q;
    issue      = (state_q == RUN) && !abort;
    last_issue = (issue_q == num_q - 1'b1);
  end

`ifdef PLAYBACK_CHECKER_BITLOG_EN
  // Priority encoder: lowest-numbered mismatching bit of the current compare
  always_comb begin
    fail_bit = '0;
    for (int i = OUT_WIDTH - 1; i >= 0; i--) begin
      if (diff[i]) fail_bit = ($clog2(OUT_WIDTH))'(i);
    end
  end
`endif

  // Next-state: delay-line shift, result accumulation and run sequencing
  always_comb begin
    state_d          = state_q;
    num_d            = num_q;
    stop_d           = stop_q;
    issue_d          = issue_q;
    drain_d          = drain_q;
    dut_in_d         = dut_in_q;
    pass_d           = pass_q;
    mismatch_count_d = mismatch_count_q;
    first_fail_idx_d = first_fail_idx_q;
`ifdef PLAYBACK_CHECKER_BITLOG_EN
    first_fail_bit_d = first_fail_bit_q;
`endif
    for (int i = CMP_LATENCY - 1; i >= 1; i--) begin
      ref_pipe_d[i]  = ref_pipe_q[i-1];
      mask_pipe_d[i] = mask_pipe_q[i-1];
      idx_pipe_d[i]  = idx_pipe_q[i-1];
      en_pipe_d[i]   = en_pipe_q[i-1];
      vld_pipe_d[i]  = vld_pipe_q[i-1];
    end
    ref_pipe_d[0]  = ref_mem[rd_addr];
    mask_pipe_d[0] = mask_mem[rd_addr];
    idx_pipe_d[0]  = rd_addr;
    en_pipe_d[0]   = (issue_q >= SKIP_IDX);
    vld_pipe_d[0]  = issue;

    if (issue) begin
      dut_in_d = stim_mem[rd_addr];
      issue_d  = issue_q + 1'b1;
    end

    if (fail) begin
      if (mismatch_count_q != '1) mismatch_count_d = mismatch_count_q + 1'b1;
      if (mismatch_count_q == '0) begin
        first_fail_idx_d = idx_pipe_q[LAST];
`ifdef PLAYBACK_CHECKER_BITLOG_EN
        first_fail_bit_d = fail_bit;
`endif
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_d            = num_vectors;
          stop_d           = stop_on_fail;
          issue_d          = '0;
          drain_d          = '0;
          vld_pipe_d       = '0;
          mismatch_count_d = '0;
          first_fail_idx_d = '0;
`ifdef PLAYBACK_CHECKER_BITLOG_EN
          first_fail_bit_d = '0;
`endif
          if (num_vectors == '0) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = RUN;
            pass_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d    = DONE;
          vld_pipe_d = '0;
          pass_d     = (mismatch_count_d == '0);
        end else if (last_issue) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (abort || drain_q == DRAIN_LAST) begin
          state_d    = DONE;
          vld_pipe_d = '0;
          pass_d     = (mismatch_count_d == '0);
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; the table is not reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      num_q            <= '0;
      stop_q           <= 1'b0;
      issue_q          <= '0;
      drain_q          <= '0;
      dut_in_q         <= '0;
      pass_q           <= 1'b0;
      mismatch_count_q <= '0;
      first_fail_idx_q <= '0;
      en_pipe_q        <= '0;
      vld_pipe_q       <= '0;
      for (int i = 0; i < CMP_LATENCY; i++) begin
        ref_pipe_q[i]  <= '0;
        mask_pipe_q[i] <= '0;
        idx_pipe_q[i]  <= '0;
      end
`ifdef PLAYBACK_CHECKER_BITLOG_EN
      first_fail_bit_q <= '0;
`endif
    end else begin
      state_q          <= state_d;
      num_q            <= num_d;
      stop_q           <= stop_d;
      issue_q          <= issue_d;
      drain_q          <= drain_d;
      dut_in_q         <= dut_in_d;
      pass_q           <= pass_d;
      mismatch_count_q <= mismatch_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      en_pipe_q        <= en_pipe_d;
      vld_pipe_q       <= vld_pipe_d;
      for (int i = 0; i < CMP_LATENCY; i++) begin
        ref_pipe_q[i]  <= ref_pipe_d[i];
        mask_pipe_q[i] <= mask_pipe_d[i];
        idx_pipe_q[i]  <= idx_pipe_d[i];
      end
`ifdef PLAYBACK_CHECKER_BITLOG_EN
      first_fail_bit_q <= first_fail_bit_d;
`endif
    end
  end

  assign dut_in         = dut_in_q;
  assign busy           = running;
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign mismatch_count = mismatch_count_q;
  assign first_fail_idx = first_fail_idx_q;
`ifdef PLAYBACK_CHECKER_BITLOG_EN
  assign first_fail_bit = first_fail_bit_q;
`endif

endmodule

// File: tb/tb_playback_checker.sv
// Testbench for playback_checker. A stand-in DUT (a fixed XOR function of
// dut_in) is wrapped around two checker instances that share every input:
// one with a 16-bit mismatch counter, one with a 2-bit counter to watch
// saturation. Expected results come from a loop over the bench's own copy of
// the vector table.

module tb_playback_checker;

  localparam int IN_W  = 361;
  localparam int OUT_W = 331;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LAT   = 1;
  localparam int SKIP  = 2;
  localparam int CW    = 16;
  localparam int CW2   = 2;
  localparam int FB_W  = $clog2(OUT_W);
  localparam int TBL   = 64;

  logic              clk;
  logic              rst_n;
  logic              load_valid;
  logic [AW-1:0]     load_addr;
  logic [IN_W-1:0]   load_stim;
  logic [OUT_W-1:0]  load_ref;
  logic [OUT_W-1:0]  load_mask;
  logic              start;
  logic [AW:0]       num_vectors;
  logic              stop_on_fail;

  logic [IN_W-1:0]   dut_in, dut_in2;
  logic [OUT_W-1:0]  dut_out, dut_out2;
  logic              busy, done, pass, busy2, done2, pass2;
  logic [CW-1:0]     mismatch_count;
  logic [CW2-1:0]    mismatch_count2;
  logic [AW-1:0]     first_fail_idx, first_fail_idx2;
`ifdef PLAYBACK_CHECKER_BITLOG_EN
  logic [FB_W-1:0]   first_fail_bit, first_fail_bit2;
`endif

  // Bench copy of the table and of the value dut_in should currently hold
  logic [IN_W-1:0]   stim_tb [TBL];
  logic [OUT_W-1:0]  ref_tb  [TBL];
  logic [OUT_W-1:0]  mask_tb [TBL];
  logic [IN_W-1:0]   prev_dut_in;

  int vectors_applied = 0;
  int miscompares     = 0;

  // Stand-in DUT: purely combinational, so one cycle of compare latency
  function automatic logic [OUT_W-1:0] fakeDut(input logic [IN_W-1:0] v);
    logic [IN_W-1:0] s;
    s = v >> 30;
    return v[OUT_W-1:0] ^ s[OUT_W-1:0];
  endfunction

  assign dut_out  = fakeDut(dut_in);
  assign dut_out2 = fakeDut(dut_in2);

  playback_checker #(
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .CMP_LATENCY(LAT), .SKIP_VECTORS(SKIP), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_addr(load_addr),
    .load_stim(load_stim), .load_ref(load_ref), .load_mask(load_mask),
    .start(start), .num_vectors(num_vectors), .stop_on_fail(stop_on_fail),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .mismatch_count(mismatch_count), .first_fail_idx(first_fail_idx)
`ifdef PLAYBACK_CHECKER_BITLOG_EN
    , .first_fail_bit(first_fail_bit)
`endif
  );

  playback_checker #(
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .CMP_LATENCY(LAT), .SKIP_VECTORS(SKIP), .CNT_WIDTH(CW2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_addr(load_addr),
    .load_stim(load_stim), .load_ref(load_ref), .load_mask(load_mask),
    .start(start), .num_vectors(num_vectors), .stop_on_fail(stop_on_fail),
    .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2), .pass(pass2),
    .mismatch_count(mismatch_count2), .first_fail_idx(first_fail_idx2)
`ifdef PLAYBACK_CHECKER_BITLOG_EN
    , .first_fail_bit(first_fail_bit2)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports any miscompare
  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle a little past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] t;
    t = '0;
    for (int w = 0; w < 16; w++) t = {t[479:0], 32'($urandom())};
    return t;
  endfunction

  function automatic logic [IN_W-1:0] randStim();
    logic [511:0] t;
    t = rand512();
    return t[IN_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] randOut();
    logic [511:0] t;
    t = rand512();
    return t[OUT_W-1:0];
  endfunction

  // Write one table entry into both checkers and the bench copy
  task automatic loadEntry(input int a, input logic [IN_W-1:0] s,
                           input logic [OUT_W-1:0] r, input logic [OUT_W-1:0] m);
    load_valid = 1'b1;
    load_addr  = AW'(a);
    load_stim  = s;
    load_ref   = r;
    load_mask  = m;
    tick();
    load_valid = 1'b0;
    stim_tb[a] = s;
    ref_tb[a]  = r;
    mask_tb[a] = m;
  endtask

  // Fresh clean table: random stimulus, exact reference, full mask
  task automatic loadClean(input int n);
    logic [IN_W-1:0] s;
    for (int a = 0; a < n; a++) begin
      s = randStim();
      loadEntry(a, s, fakeDut(s), '1);
    end
  endtask

  // Flip one reference bit of an entry already in the table
  task automatic corruptRef(input int a, input int b);
    logic [OUT_W-1:0] r;
    r    = ref_tb[a];
    r[b] = ~r[b];
    loadEntry(a, stim_tb[a], r, mask_tb[a]);
  endtask

  // All observable outputs must be at their reset values
  task automatic checkResetState(input string name);
    checkOutput({name, "/dut_in"}, dut_in, '0);
    checkOutput({name, "/busy"}, busy, 0);
    checkOutput({name, "/done"}, done, 0);
    checkOutput({name, "/pass"}, pass, 0);
    checkOutput({name, "/count"}, mismatch_count, 0);
    checkOutput({name, "/ffidx"}, first_fail_idx, 0);
    checkOutput({name, "/count2"}, mismatch_count2, 0);
`ifdef PLAYBACK_CHECKER_BITLOG_EN
    checkOutput({name, "/ffbit"}, first_fail_bit, 0);
`endif
  endtask

  // One complete run: predict the outcome from the table, start the checker,
  // follow busy/done/dut_in every cycle, then check the results. With
  // interfere set, a start pulse and a table write are thrown in mid-run and
  // must have no effect.
  task automatic applyStimulus(input int n, input bit stop, input bit interfere,
                               input string name);
    int exp_cnt, exp_first, exp_bit, abort_k, last_drv, exp_ticks, m;
    bit drove;
    logic [OUT_W-1:0] d;
    exp_cnt = 0; exp_first = 0; exp_bit = 0; abort_k = -1;
    for (int k = 0; k < n; k++) begin
      d = (fakeDut(stim_tb[k]) ^ ref_tb[k]) & mask_tb[k];
      if (k >= SKIP && d != '0) begin
        if (exp_cnt == 0) begin
          exp_first = k;
          for (int b = 0; b < OUT_W; b++) begin
            if (d[b]) begin
              exp_bit = b;
              break;
            end
          end
        end
        exp_cnt++;
        if (stop) begin
          abort_k = k;
          break;
        end
      end
    end
    if (n == 0) begin
      exp_ticks = 1; drove = 1'b0; last_drv = 0;
    end else if (abort_k >= 0) begin
      exp_ticks = 2 + abort_k + LAT;
      last_drv  = (abort_k + LAT - 1 < n - 1) ? abort_k + LAT - 1 : n - 1;
      drove     = 1'b1;
    end else begin
      exp_ticks = n + LAT + 1; last_drv = n - 1; drove = 1'b1;
    end

    num_vectors  = (AW+1)'(n);
    stop_on_fail = stop;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= exp_ticks; j++) begin
      checkOutput({name, "/busy"}, busy, (j < exp_ticks));
      checkOutput({name, "/done"}, done, (j == exp_ticks));
      if (drove && j >= 2) begin
        m = (j - 2 < last_drv) ? j - 2 : last_drv;
        checkOutput({name, "/dut_in"}, dut_in, stim_tb[m]);
      end else begin
        checkOutput({name, "/dut_in"}, dut_in, prev_dut_in);
      end
      if (j == 1 && interfere && exp_ticks > 1) begin
        start        = 1'b1;
        num_vectors  = (AW+1)'($urandom_range(0, 20));
        stop_on_fail = 1'($urandom_range(0, 1));
        load_valid   = 1'b1;
        load_addr    = AW'($urandom_range(0, TBL - 1));
        load_stim    = randStim();
        load_ref     = randOut();
        load_mask    = randOut();
      end else begin
        start      = 1'b0;
        load_valid = 1'b0;
      end
      if (j < exp_ticks) tick();
    end
    start      = 1'b0;
    load_valid = 1'b0;

    checkOutput({name, "/pass"}, pass, (exp_cnt == 0));
    checkOutput({name, "/count"}, mismatch_count, exp_cnt);
    checkOutput({name, "/ffidx"}, first_fail_idx, exp_first);
    checkOutput({name, "/count2"}, mismatch_count2, (exp_cnt > 3) ? 3 : exp_cnt);
`ifdef PLAYBACK_CHECKER_BITLOG_EN
    checkOutput({name, "/ffbit"}, first_fail_bit, exp_bit);
`endif
    if (drove) prev_dut_in = stim_tb[last_drv];
  endtask

  // Directed scenarios first, then randomized runs, then mid-run reset
  initial begin
    logic [OUT_W-1:0] mk;
    logic [IN_W-1:0]  s;
    rst_n = 1'b0; load_valid = 1'b0; load_addr = '0; load_stim = '0;
    load_ref = '0; load_mask = '0; start = 1'b0; num_vectors = '0;
    stop_on_fail = 1'b0; prev_dut_in = '0;
    repeat (3) tick();
    checkResetState("reset");
    rst_n = 1'b1;
    tick();

    loadClean(8);
    applyStimulus(8, 1'b0, 1'b0, "clean8");

    corruptRef(5, 3);
    applyStimulus(8, 1'b0, 1'b0, "ref5bit3");

    mk = '1; mk[3] = 1'b0;
    loadEntry(5, stim_tb[5], ref_tb[5], mk);
    applyStimulus(8, 1'b0, 1'b0, "masked5");

    loadEntry(5, stim_tb[5], fakeDut(stim_tb[5]), '1);
    corruptRef(1, 7);
    applyStimulus(8, 1'b0, 1'b0, "skip1");

    loadEntry(1, stim_tb[1], fakeDut(stim_tb[1]), '1);
    corruptRef(3, 10);
    corruptRef(6, 200);
    applyStimulus(8, 1'b0, 1'b0, "two_fail");
    applyStimulus(8, 1'b1, 1'b0, "stop_fail");

    loadClean(8);
    for (int a = 2; a < 8; a++) corruptRef(a, a * 11);
    applyStimulus(8, 1'b0, 1'b1, "saturate");

    applyStimulus(0, 1'b0, 1'b0, "zero_vec");

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, 40);
      for (int a = 0; a < n; a++) begin
        s  = randStim();
        mk = fakeDut(s);
        if ($urandom_range(0, 2) == 0) mk[$urandom_range(0, OUT_W - 1)] ^= 1'b1;
        loadEntry(a, s, mk, randOut());
      end
      applyStimulus(n, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rand%0d", r));
    end

    loadClean(8);
    num_vectors  = 9'd8;
    stop_on_fail = 1'b0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    checkResetState("midreset");
    rst_n = 1'b1;
    prev_dut_in = '0;
    applyStimulus(8, 1'b0, 1'b0, "replay");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/playback_checker.md
# playback_checker

Synthesizable, parametrised successor to the simulation playback driver for block-level gate checks. It holds a stimulus/reference/mask vector table and drives stimulus vectors onto a DUT's packed input bus, one per clock. It compares the DUT's packed output bus against masked reference vectors after a configurable latency and reports pass/fail, the mismatch count and the first failing vector. It sits between a table loader (bench or on-chip debug port) and any DUT wrapper such as the dynamic node.

## Interface
- IN_WIDTH, 361, stimulus vector width
- OUT_WIDTH, 331, DUT output/reference/mask width
- DEPTH, 1024, vector table entries
- ADDR_WIDTH, 10, log2(DEPTH)
- CMP_LATENCY, 1, cycles from dut_in change to comparable dut_out (1..8)
- SKIP_VECTORS, 2, leading vectors driven but never compared
- CNT_WIDTH, 16, mismatch counter width
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- load_valid  in  1  write table entry load_addr
- load_addr  in  ADDR_WIDTH  table index
- load_stim  in  IN_WIDTH  stimulus word
- load_ref  in  OUT_WIDTH  expected output
- load_mask  in  OUT_WIDTH  1 = compare bit, 0 = don't care
- start  in  1  begin run (pulse)
- num_vectors  in  ADDR_WIDTH+1  vectors to play, sampled on start
- stop_on_fail  in  1  abort at first mismatch, sampled on start
- dut_in  out  IN_WIDTH  registered stimulus to DUT
- dut_out  in  OUT_WIDTH  DUT response
- busy  out  1  run in progress
- done  out  1  run finished, held until next start
- pass  out  1  valid when done; 1 iff mismatch_count == 0
- mismatch_count  out  CNT_WIDTH  failing compares, saturating
- first_fail_idx  out  ADDR_WIDTH  vector index of first failure

## Operation
- FSM states:
  - IDLE: loads accepted. start → RUN, clears count, done, pass and first-fail regs. num_vectors == 0 → DONE directly.
  - RUN: issue index k = 0..num_vectors-1, one per cycle. After last issue → DRAIN.
  - DRAIN: wait CMP_LATENCY cycles for outstanding compares → DONE.
  - DONE: done = 1. Loads accepted. start → RUN.
- Table writes are ignored while busy. start is ignored while busy.
- Issue k: dut_in <= stim[k]. ref[k], mask[k], k and compare-enable (k >= SKIP_VECTORS) enter a CMP_LATENCY-deep delay line.
- Compare: fail = enable & |((dut_out ^ ref) & mask).
- On fail:
  - Increment mismatch_count, saturating at all-ones.
  - If it is the first fail of the run, latch first_fail_idx.
- stop_on_fail = 1: first fail moves the FSM to DONE on the next cycle. Remaining issues and in-flight compares are discarded, so the count is 1.
- pass = (mismatch_count == 0), registered on entry to DONE.

## Timing
- Reset values: dut_in = 0, busy = 0, done = 0, pass = 0, mismatch_count = 0, first_fail_idx = 0, FSM = IDLE.
- Run sequencing:
  - start sampled at edge t → busy = 1 from t+1.
  - stim[0] appears on dut_in at t+2, because the table read is registered.
  - stim[k] is on dut_in at t+2+k.
  - The compare for k samples dut_out at the edge ending cycle t+2+k+CMP_LATENCY-1.
- done rises the cycle after the last compare. busy falls the same cycle.
- Total run: num_vectors + CMP_LATENCY + 2 cycles.
- dut_in holds the last issued vector after the run ends.
- A load to the index currently being issued is impossible, because loads are blocked while busy.
- rst_n low mid-run returns all outputs to reset values at the next edge. The table contents are retained.

## Configuration
- PLAYBACK_CHECKER_BITLOG_EN defined:
  - Adds output first_fail_bit [$clog2(OUT_WIDTH)-1:0].
  - Holds the lowest-numbered mismatching bit of the first failing compare, from a priority encoder on the masked XOR.
  - Reset and start-clear value is 0.
- Undefined: port and encoder absent. All other behaviour is identical.

## Test plan
- Load 8 vectors with ref = actual DUT response and all-ones mask; start with num_vectors = 8 → done after 8+CMP_LATENCY+2 cycles, pass = 1, mismatch_count = 0.
- Corrupt ref[5] bit 3 → pass = 0, mismatch_count = 1, first_fail_idx = 5, first_fail_bit = 3 with the macro.
- Same corruption with mask[5] bit 3 = 0 → pass = 1; corrupt ref[1] instead (index < SKIP_VECTORS) → pass = 1.
- Corrupt ref[3] and ref[6]:
  - stop_on_fail = 0 → mismatch_count = 2, first_fail_idx = 3.
  - stop_on_fail = 1 → mismatch_count = 1, done the cycle after the vector-3 compare, vectors 4+ never driven.
- CNT_WIDTH = 2, 6 failing vectors → mismatch_count saturates at 3; num_vectors = 0 → done two cycles after start, pass = 1.
- Assert rst_n = 0 for one cycle during RUN → all outputs at reset values next cycle; restart replays from vector 0 with the table intact.
